// File: rtl/risc_mem_pkg.sv
// Shared definitions for the data-RAM port arbiter.
//   ADDR_W_DEF / DATA_W_DEF : default RAM geometry (32 x 32-bit words)
//   BYTES_PER_WORD          : bytes streamed per host readout
//   arb_state_t             : arbiter FSM states
package risc_mem_pkg;
    localparam int ADDR_W_DEF     = 5;
    localparam int DATA_W_DEF     = 32;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT    = 3'd1,
        GRANT   = 3'd2,
        CAPTURE = 3'd3,
        SHIFT   = 3'd4
    } arb_state_t;
endpackage

// File: rtl/word_byte_shifter.sv
// Loads one 32-bit word and streams it out as 4 bytes, LSB first.
//   clk, rst : clock, synchronous active-high reset
//   i_load   : capture i_word and start streaming on the next cycle
//   i_word   : word to stream
//   o_byte   : current byte
//   o_valid  : o_byte valid this cycle
//   o_last   : marks the final byte of the word
module word_byte_shifter
    import risc_mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_word,
    output logic [7:0]        o_byte,
    output logic              o_valid,
    output logic              o_last
);
    logic [DATA_W-1:0] r_word;
    logic [1:0]        r_idx;
    logic              r_active;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_word   <= '0;
            r_idx    <= '0;
            r_active <= 1'b0;
        end else if (i_load) begin
            r_word   <= i_word;
            r_idx    <= '0;
            r_active <= 1'b1;
        end else if (r_active) begin
            r_idx <= r_idx + 2'd1;
            if (r_idx == 2'(BYTES_PER_WORD - 1))
                r_active <= 1'b0;
        end
    end

    assign o_byte  = r_word[8*r_idx +: 8];
    assign o_valid = r_active;
    assign o_last  = r_active && (r_idx == 2'(BYTES_PER_WORD - 1));
endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the single-port data RAM between the CPU load/store port
// (priority) and a host readout channel that fetches one word and streams
// it as 4 bytes on the debug output. The host is forced a one-cycle grant
// after waiting STARVE_MAX cycles under CPU traffic.
//   clk, rst                        : clock, synchronous active-high reset
//   cpu_req/we/addr/wdata           : CPU access request
//   cpu_rdata, cpu_stall            : CPU load data (next cycle), stall
//   host_req, host_addr, host_busy  : host readout request / status
//   byte_out, byte_valid, byte_last : streamed bytes
//   ram_we/addr/wdata, ram_rdata    : RAM port (1-cycle read latency)
module ram_port_arbiter
    import risc_mem_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              host_req,
    input  logic [ADDR_W-1:0] host_addr,
    output logic              host_busy,
    output logic [7:0]        byte_out,
    output logic              byte_valid,
    output logic              byte_last,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);
    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    arb_state_t        r_state;
    logic [SW-1:0]     r_starve;
    logic [ADDR_W-1:0] r_host_addr;
    logic              w_grant;
    logic              w_last;

    assign w_grant = (r_state == GRANT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_starve    <= '0;
            r_host_addr <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (host_req) begin
                        r_host_addr <= host_addr;
                        r_state     <= WAIT;
                    end
                end
                WAIT: begin
                    // CPU keeps the port while it is busy, but only for
                    // STARVE_MAX cycles in a row.
                    if (!cpu_req || r_starve == SW'(STARVE_MAX))
                        r_state <= GRANT;
                    else
                        r_starve <= r_starve + SW'(1);
                end
                GRANT: begin
                    r_starve <= '0;
                    r_state  <= CAPTURE;
                end
                CAPTURE: r_state <= SHIFT;
                SHIFT: begin
                    if (w_last)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // The host owns the RAM port only during GRANT; the CPU is stalled
    // then and its store is suppressed until it re-presents it.
    assign cpu_stall = w_grant & cpu_req;
    assign ram_addr  = w_grant ? r_host_addr : cpu_addr;
    assign ram_we    = ~w_grant & cpu_req & cpu_we;
    assign ram_wdata = cpu_wdata;
    assign cpu_rdata = ram_rdata;
    assign host_busy = (r_state != IDLE);

    // ram_rdata in CAPTURE is the host word addressed during GRANT, so
    // later CPU writes to that address cannot disturb the stream.
    word_byte_shifter #(.DATA_W(DATA_W)) u_shifter (
        .clk     (clk),
        .rst     (rst),
        .i_load  (r_state == CAPTURE),
        .i_word  (ram_rdata),
        .o_byte  (byte_out),
        .o_valid (byte_valid),
        .o_last  (w_last)
    );

    assign byte_last = w_last;
endmodule
